alu: RTL and testbench



---
 rtl/mcpu_pkg.sv | 14 +
 rtl/alu_comb.sv | 31 +++
 rtl/alu.sv | 40 ++++
 tb/tb_alu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared mCPU datapath constants: data width, bus type and ALU op codes.
// Imported by the ALU and its combinational core.
package mcpu_pkg;

  localparam int DATAW = 16;

  typedef logic [DATAW-1:0] databus_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: o_res = f(i_op, i_x, i_y), modulo 2^DATAW.
// Ports: i_op (2b op), i_x/i_y (operands), o_res (result).
module alu_comb
  import mcpu_pkg::*;
#(
  parameter int DATAW = mcpu_pkg::DATAW
) (
  input  logic [1:0]       i_op,
  input  logic [DATAW-1:0] i_x,
  input  logic [DATAW-1:0] i_y,
  output logic [DATAW-1:0] o_res
);

  logic [DATAW-1:0] w_res;

  // Carry/borrow fall off the top; SUB wraps naturally.
  // The default arm keeps an unknown op from poisoning the result.
  always_comb begin
    w_res = '0;
    case (i_op)
      OP_ADD:  w_res = i_x + i_y;
      OP_SUB:  w_res = i_x - i_y;
      OP_AND:  w_res = i_x & i_y;
      OP_OR:   w_res = i_x | i_y;
      default: w_res = i_x + i_y;
    endcase
  end

  assign o_res = w_res;

endmodule

// File: rtl/alu.sv
// Registered 2-operand ALU: result of op(d_inX, d_inY) captured on clk when ena=1.
// Ports: clk, rst (async high), ena, d_inX, d_inY, op, d_out (registered).
module alu
  import mcpu_pkg::*;
#(
  parameter int DATAW = mcpu_pkg::DATAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DATAW-1:0] d_inX,
  input  logic [DATAW-1:0] d_inY,
  input  logic [1:0]       op,
  output logic [DATAW-1:0] d_out
);

  logic [DATAW-1:0] w_res;
  logic [DATAW-1:0] r_out;

  alu_comb #(
    .DATAW (DATAW)
  ) u_comb (
    .i_op  (op),
    .i_x   (d_inX),
    .i_y   (d_inY),
    .o_res (w_res)
  );

  // Only the register drives d_out, so operand churn never glitches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (ena) begin
      r_out <= w_res;
    end
  end

  assign d_out = r_out;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus random ops against
// an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] d_inX;
  logic [15:0] d_inY;
  logic [1:0]  op;
  logic [15:0] d_out;

  int          checks;
  int          errors;
  logic [15:0] exp_q;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .d_inX (d_inX),
    .d_inY (d_inY),
    .op    (op),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(int o, int x, int y);
    int r;
    case (o)
      0: r = (x + y) % 65536;
      1: r = (x - y + 65536) % 65536;
      2: r = x & y;
      default: r = x | y;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [15:0] e);
    checks++;
    assert (d_out === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, d_out, e);
    end
  endtask

  // Advance one rising edge, update the model, sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) exp_q = 16'd0;
    else if (ena) exp_q = ref_alu(int'(op), int'(d_inX), int'(d_inY));
    #1;
  endtask

  task automatic setin(input int o, input int x, input int y);
    op    = 2'(o);
    d_inX = 16'(x);
    d_inY = 16'(y);
  endtask

  logic [15:0] seq_exp [4];
  logic [15:0] held;

  initial begin
    checks = 0;
    errors = 0;
    exp_q  = 16'd0;
    rst    = 1'b1;
    ena    = 1'b0;
    setin(0, 0, 0);
    seq_exp[0] = 16'd14443;
    seq_exp[1] = 16'd3333;
    seq_exp[2] = 16'd176;
    seq_exp[3] = 16'd14267;

    tick();
    tick();
    check("reset_state", 16'd0);

    #2 rst = 1'b0;
    setin(0, 8888, 5555);
    tick();
    check("release_no_ena", 16'd0);

    ena = 1'b1;
    for (int o = 0; o < 4; o++) begin
      op = 2'(o);
      tick();
      check("seq_const", seq_exp[o]);
      check("seq_model", exp_q);
    end

    op = 2'd0;
    tick();
    check("pre_rst_add", 16'd14443);
    #3 rst = 1'b1;
    #1 check("async_rst", 16'd0);
    exp_q = 16'd0;
    tick();
    check("rst_held", 16'd0);
    ena = 1'b0;
    #2 rst = 1'b0;
    tick();
    check("rst_release_hold", 16'd0);
    ena = 1'b1;
    tick();
    check("first_after_rst", 16'd14443);

    for (int o = 0; o < 4; o++) begin
      setin(o, 2321, 1234);
      tick();
      check("ops_2321_1234", exp_q);
    end

    setin(1, 234, 6546);
    tick();
    check("sub_wrap", 16'd59224);
    setin(0, 65535, 1);
    tick();
    check("add_wrap", 16'd0);
    setin(1, 0, 1);
    tick();
    check("zero_minus_one", 16'hFFFF);

    setin(0, 8888, 5555);
    tick();
    held = exp_q;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setin(i + 1, 100 * i + 7, 3 * i + 1);
      tick();
      check("hold", held);
    end
    ena = 1'b1;
    tick();
    check("hold_release", exp_q);

    setin(0, 2321, 1234);
    tick();
    check("lat_base", 16'd3555);
    op = 2'd1;
    #2 check("lat_no_comb", 16'd3555);
    tick();
    check("lat_next_edge", 16'd1087);

    for (int i = 0; i < 300; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      setin(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)));
      if ($urandom_range(0, 7) == 0) begin
        setin(int'($urandom_range(0, 1)), 65535 * int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)));
      end
      tick();
      check("random", exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
